// File: rtl/ap_result_packer_pkg.sv
// Shared types and constants for the AP result packer: FSM state encoding, default geometry
// and FP32 exponent field position used by the optional Inf/NaN detector.
package ap_result_packer_pkg;

   typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_e;

   localparam int unsigned ELEMENT_WIDTH = 32;
   localparam int unsigned NO_OF_UNITS   = 8;
   localparam int unsigned ADDR_WIDTH    = 10;

   localparam int unsigned FP32_EXP_LSB = 23;
   localparam int unsigned FP32_EXP_MSB = 30;

   // Exponent all ones means Inf or NaN regardless of mantissa.
   function automatic logic is_inf_nan(input logic [31:0] v);
      return &v[FP32_EXP_MSB:FP32_EXP_LSB];
   endfunction

endpackage

// File: rtl/ap_result_packer_lane_packer.sv
// Lane insert register: places each accepted scalar into the next lane of a wide word and
// flags when the word is complete (all lanes filled or last element of the row set).
module ap_result_packer_lane_packer
   import ap_result_packer_pkg::*;
#(
   parameter int unsigned ElementWidth = ELEMENT_WIDTH,
   parameter int unsigned NoOfUnits    = NO_OF_UNITS
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              clear_i,
   input  logic                              valid_i,
   input  logic                              last_i,
   input  logic [ElementWidth-1:0]           data_i,
   output logic                              complete_o,
   output logic [ElementWidth*NoOfUnits-1:0] word_o
);

   localparam int unsigned LaneW = (NoOfUnits > 1) ? $clog2(NoOfUnits) : 1;
   localparam int unsigned DataW = ElementWidth * NoOfUnits;

   logic [LaneW-1:0] lane_q, lane_d;
   logic [DataW-1:0] pack_q, pack_d, pack_ins;

   always_comb begin
      pack_ins = pack_q;
      for (int unsigned i = 0; i < NoOfUnits; i++) begin
         if (lane_q == LaneW'(i)) begin
            pack_ins[i*ElementWidth +: ElementWidth] = data_i;
         end
      end
   end

   assign complete_o = valid_i & ((lane_q == LaneW'(NoOfUnits - 1)) | last_i);
   // Word handed out includes the element arriving this cycle.
   assign word_o     = pack_ins;

   always_comb begin
      pack_d = pack_q;
      lane_d = lane_q;
      if (clear_i) begin
         pack_d = '0;
         lane_d = '0;
      end else if (valid_i) begin
         if (complete_o) begin
            pack_d = '0;
            lane_d = '0;
         end else begin
            pack_d = pack_ins;
            lane_d = lane_q + LaneW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pack_q <= '0;
         lane_q <= '0;
      end else begin
         pack_q <= pack_d;
         lane_q <= lane_d;
      end
   end

endmodule

// File: rtl/ap_result_packer.sv
// Packs consecutive AP scalars into wide words written to the AP total memory, then reports
// completion. Define NAN_CHECK_EN to add the sticky nan_seen_o Inf/NaN detector output.
module ap_result_packer
   import ap_result_packer_pkg::*;
#(
   parameter int unsigned ElementWidth = ELEMENT_WIDTH,
   parameter int unsigned NoOfUnits    = NO_OF_UNITS,
   parameter int unsigned AddrWidth    = ADDR_WIDTH
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              start_i,
   input  logic [31:0]                       total_i,
   input  logic [ElementWidth-1:0]           result_i,
   input  logic                              finish_i,
   output logic                              AP_total_mem_we_o,
   output logic [AddrWidth-1:0]              ap_mem_addr_o,
   output logic [ElementWidth*NoOfUnits-1:0] ap_mem_data_o,
   output logic                              busy_o,
   output logic                              done_o,
`ifdef NAN_CHECK_EN
   output logic                              nan_seen_o,
`endif
   output logic                              overrun_o
);

   localparam int unsigned DataW = ElementWidth * NoOfUnits;

   state_e               state_q, state_d;
   logic [31:0]          total_q, total_d;
   logic [31:0]          count_q, count_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [DataW-1:0]     data_q, data_d;
   logic                 we_q, we_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 overrun_q, overrun_d;

   logic                 accept, take, last, complete;
   logic [DataW-1:0]     packed_word;

   assign accept = start_i & ~busy_q & ((state_q == StIdle) | (state_q == StDone));
   assign take   = finish_i & (state_q == StCollect);
   assign last   = (count_q + 32'd1) == total_q;

   ap_result_packer_lane_packer #(
      .ElementWidth(ElementWidth),
      .NoOfUnits   (NoOfUnits)
   ) u_lane_packer (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clear_i   (accept),
      .valid_i   (take),
      .last_i    (last),
      .data_i    (result_i),
      .complete_o(complete),
      .word_o    (packed_word)
   );

   always_comb begin
      state_d   = state_q;
      total_d   = total_q;
      count_d   = count_q;
      addr_d    = addr_q;
      data_d    = data_q;
      we_d      = 1'b0;
      busy_d    = busy_q;
      done_d    = done_q;
      overrun_d = overrun_q;

      // Address advances once the write cycle has been presented.
      if (we_q) begin
         addr_d = addr_q + AddrWidth'(1);
      end

      unique case (state_q)
         StIdle, StDone: begin
            // Zero-length request lands here with busy still set for one cycle.
            if ((state_q == StDone) && busy_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
            if (accept) begin
               total_d = total_i;
               count_d = '0;
               addr_d  = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               state_d = (total_i == 32'd0) ? StDone : StCollect;
            end
         end
         StCollect: begin
            if (take) begin
               count_d = count_q + 32'd1;
               if (complete) begin
                  data_d = packed_word;
                  we_d   = 1'b1;
                  if (last) begin
                     state_d = StFlush;
                  end
               end
            end
         end
         StFlush: begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      // A finish coinciding with an accepted start is still flagged.
      if (accept) begin
         overrun_d = 1'b0;
      end
      if (finish_i && (state_q != StCollect)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         total_q   <= '0;
         count_q   <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         total_q   <= total_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         we_q      <= we_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   assign AP_total_mem_we_o = we_q;
   assign ap_mem_addr_o     = addr_q;
   assign ap_mem_data_o     = data_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign overrun_o         = overrun_q;

`ifdef NAN_CHECK_EN
   logic nan_q, nan_d;

   always_comb begin
      nan_d = nan_q;
      if (accept) begin
         nan_d = 1'b0;
      end
      if (take && is_inf_nan(result_i[31:0])) begin
         nan_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         nan_q <= 1'b0;
      end else begin
         nan_q <= nan_d;
      end
   end

   assign nan_seen_o = nan_q;
`endif

endmodule

// File: tb/tb_ap_result_packer.sv
// Self-checking bench for ap_result_packer: directed scenarios with random data and gaps,
// checked against a word-level model of the packed memory image and write timing.
module tb_ap_result_packer;

   localparam int unsigned W  = 32;
   localparam int unsigned N  = 8;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = W * N;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [31:0]   total;
   logic [W-1:0]  result;
   logic          finish;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          busy;
   logic          done;
   logic          overrun;
`ifdef NAN_CHECK_EN
   logic          nan_seen;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   ap_result_packer #(
      .ElementWidth(W),
      .NoOfUnits   (N),
      .AddrWidth   (AW)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .start_i          (start),
      .total_i          (total),
      .result_i         (result),
      .finish_i         (finish),
      .AP_total_mem_we_o(we),
      .ap_mem_addr_o    (addr),
      .ap_mem_data_o    (data),
      .busy_o           (busy),
      .done_o           (done),
`ifdef NAN_CHECK_EN
      .nan_seen_o       (nan_seen),
`endif
      .overrun_o        (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   logic [AW-1:0] wr_addr[$];
   logic [DW-1:0] wr_data[$];
   int            wr_cyc[$];

   always @(negedge clk) begin
      if (we === 1'b1) begin
         wr_addr.push_back(addr);
         wr_data.push_back(data);
         wr_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   // mode 0: random data, 1: values 1..n, 2: random with Inf/NaN pattern as the 4th element.
   // sf drives a finish in the same cycle as start.
   task automatic do_run(input int tot, input int nfin, input int maxgap, input int mode,
                         input bit sf);
      int unsigned   el[$];
      int            fc[$];
      int            nacc;
      int            nwords;
      int            li;
      int            t;
      int unsigned   v;
      logic [DW-1:0] w;
      bit            exp_nan;

      clear_log();
      start  = 1'b1;
      total  = tot;
      finish = sf;
      result = 32'hDEAD_BEEF;
      step();
      start  = 1'b0;
      finish = 1'b0;
      for (int i = 0; i < nfin; i++) begin
         repeat ($urandom_range(maxgap, 0)) step();
         v = (mode == 1) ? i + 1 : $urandom;
         if (mode == 2 && i == 3) v = 32'h7FC0_0000;
         el.push_back(v);
         fc.push_back(cyc);
         result = v;
         finish = 1'b1;
         step();
         finish = 1'b0;
      end
      t = 0;
      while (t < 300 && done !== 1'b1) begin
         step();
         t++;
      end
      step();
      chk("done", done, 1);
      chk("busy_end", busy, 0);

      nacc   = (nfin < tot) ? nfin : tot;
      nwords = (nacc + N - 1) / N;
      chk("wr_count", wr_addr.size(), nwords);
      for (int k = 0; k < nwords; k++) begin
         if (k < wr_addr.size()) begin
            w = '0;
            for (int j = 0; j < N; j++) begin
               if (k * N + j < nacc) w[j*W +: W] = el[k*N+j];
            end
            li = (k * N + N - 1 < nacc - 1) ? k * N + N - 1 : nacc - 1;
            chk("wr_addr", wr_addr[k], k % (1 << AW));
            chk("wr_data", wr_data[k], w);
            chk("wr_cycle", wr_cyc[k], fc[li] + 1);
         end
      end
      chk("overrun", overrun, (sf || nfin > tot) ? 1 : 0);

      exp_nan = 1'b0;
      for (int i = 0; i < nacc; i++) begin
         if (((el[i] >> 23) & 32'hFF) == 32'hFF) exp_nan = 1'b1;
      end
`ifdef NAN_CHECK_EN
      chk("nan_seen", nan_seen, exp_nan);
`else
      if (exp_nan) $display("note: Inf/NaN element present, detector not built");
`endif
   endtask

   initial begin
      int tot;
      reset  = 1'b1;
      start  = 1'b0;
      finish = 1'b0;
      total  = '0;
      result = '0;
      @(negedge clk);
      chk("rst_we", we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_addr", addr, 0);
      chk("rst_data", data, 0);
      step();
      reset = 1'b0;
      step();

      // Two full words, back-to-back finish.
      do_run(16, 16, 0, 1, 1'b0);
      // Partial last word with random gaps.
      do_run(11, 11, 3, 0, 1'b0);

      // Zero-length request: one-cycle busy, done two cycles after start, no write.
      clear_log();
      start = 1'b1;
      total = 0;
      step();
      start = 1'b0;
      chk("zero_busy1", busy, 1);
      chk("zero_done1", done, 0);
      step();
      chk("zero_busy2", busy, 0);
      chk("zero_done2", done, 1);
      repeat (3) step();
      chk("zero_writes", wr_addr.size(), 0);

      // Extra finishes past total flag overrun; the next start clears it.
      do_run(8, 10, 1, 0, 1'b0);
      do_run(5, 5, 2, 0, 1'b0);
      // Start and finish together in an idle state.
      do_run(9, 9, 0, 0, 1'b1);

      // Asynchronous reset mid-collect.
      clear_log();
      start = 1'b1;
      total = 8;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         result = $urandom;
         finish = 1'b1;
         step();
      end
      finish = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_we", we, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_addr", addr, 0);
      chk("arst_data", data, 0);
      step();
      reset = 1'b0;
      step();
      step();
      chk("arst_writes", wr_addr.size(), 0);
      do_run(8, 8, 0, 0, 1'b0);

      // Inf/NaN element still packed intact.
      do_run(8, 8, 0, 2, 1'b0);

      repeat (4) begin
         tot = $urandom_range(30, 1);
         do_run(tot, tot + $urandom_range(2, 0), $urandom_range(3, 0), 0, 1'($urandom_range(1, 0)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ap_result_packer.md
Name: ap_result_packer

Overview:
- Downstream stage of the matrix-vector dot-product unit; consumes one scalar AP element per `finish` strobe.
- Packs no_of_units consecutive scalars into one wide word and writes it to the AP total memory at an auto-incremented address.
- Flushes a zero-padded partial word at end of row set, then reports completion to the CG sequencer.

Parameters:
- element_width, 32, bits per scalar element (IEEE-754 single).
- no_of_units, 8, elements per packed memory word.
- addr_width, 10, AP memory word-address width.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse; begins collection of `total` elements.
- total, input, 32, number of AP elements (rows) to collect; sampled on accepted start.
- result, input, element_width, scalar from dot-product unit.
- finish, input, 1, result valid strobe; may be high every cycle.
- AP_total_mem_we, output, 1, memory write enable, one cycle per packed word.
- ap_mem_addr, output, addr_width, word address for the write.
- ap_mem_data, output, element_width*no_of_units, packed word.
- busy, output, 1, high from accepted start until done.
- done, output, 1, high in DONE until next accepted start.
- overrun, output, 1, sticky: finish seen while not COLLECTing or beyond total.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; lane index, element count and address counter cleared; pack register cleared.
- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE/DONE + start: latch total, clear counters, address=0, pack register=0, done=0, busy=1. Next state is COLLECT, or DONE directly if total==0 (no write, done=1 next cycle).
- Start while busy is ignored.
- COLLECT + finish: result is stored at bits [lane*element_width +: element_width]; lane 0 is the first element; lane++ and count++.
  - When lane==no_of_units-1, or count reaches total, the pack register (including the current element) is copied to ap_mem_data.
  - Next cycle: AP_total_mem_we=1 with ap_mem_addr equal to the current address. The address increments after the write cycle. Lane resets to 0 and the pack register is cleared to zeros.
- Back-to-back finish is accepted with no stall: the output register decouples packing from the write.
- Write latency: 1 cycle after the completing finish.
- Last element: when count reaches total on a partial word, unused lanes are 0. State goes to FLUSH, which issues the single write cycle. Next state is DONE (done=1, busy=0).
- Exact multiple of no_of_units: the final full-word write also passes through FLUSH. Never issue an extra empty word.
- Words written = ceil(total/no_of_units). Address wraps modulo 2^addr_width without error.
- finish in IDLE, FLUSH or DONE: data dropped, overrun=1 (sticky until next accepted start or reset).
- Start and finish in the same cycle in IDLE: start is accepted, finish is dropped and flagged.
- Reset mid-COLLECT aborts immediately; no partial write is issued.

Optional Feature:
- Macro NAN_CHECK_EN.
- Defined: adds output nan_seen (1 bit). It is set sticky when any accepted result has exponent bits [30:23] all ones (Inf/NaN), and cleared on reset or accepted start.
- Not defined: no port, no logic; data path identical.

Decomposition:
- Shared package (cg_pkg): state encoding enum (IDLE, COLLECT, FLUSH, DONE), ELEMENT_WIDTH/NO_OF_UNITS default constants, FP32 exponent field position constants.
- One natural sub-module: ap_lane_packer. It holds the shift/lane insert register, lane counter and word-complete flag.
- The FSM, address counter and flags stay in the top.

Test Plan:
- total=16, no_of_units=8, finish every cycle with values 1..16:
  - 2 writes: addr 0 holds lanes 1..8, addr 1 holds 9..16.
  - First we 1 cycle after the 8th finish.
  - done rises after the 2nd write; overrun=0.
- total=11, finish with gaps of 0–3 cycles:
  - 2 writes; word 1 holds 9,10,11 in lanes 0–2, lanes 3–7 = 0.
  - Exactly 2 we pulses.
- total=0, start: no we, done=1 two cycles after start, busy pulse only 1 cycle.
- total=8, 10 finishes: 1 write, overrun=1 after 9th finish, done=1; next start clears overrun.
- Assert reset asynchronously after 5 of 8 finishes:
  - Outputs go 0 immediately, no write.
  - A fresh start with total=8 writes to addr 0.
- NAN_CHECK_EN build, total=8 with 4th result 32'h7FC00000:
  - nan_seen=1 after that finish; packed word still written intact.
